fft_mag_peak: RTL and testbench

// - Sits directly downstream of the FFT stage. Consumes its complex-bin AXI-Stream of FFT_CHANNELS lanes.
// - Per lane: computes |X|^2 = re^2 + im^2 and forwards it as a magnitude stream.
// - Per lane: tracks the peak bin of each frame and emits a one-beat peak report when the frame ends.

---
 rtl/fft_dsp_pkg.sv | 38 +++
 rtl/fft_mag_lane.sv | 108 ++++++++++
 rtl/fft_mag_peak.sv | 160 ++++++++++++++++
 tb/tb_fft_mag_peak.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_dsp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_dsp_pkg
//  Description : Shared widths, types and helpers for the FFT post-processing
//                blocks (magnitude / peak detection).
//  Revision    : 1.0  initial release
// ============================================================================
package fft_dsp_pkg;

    // Width of one real or imaginary component of an FFT bin.
    localparam int BIN_W       = 16;
    // Width of an unsigned |X|^2 magnitude.
    localparam int MAG_W       = 32;
    // Width of one lane of the peak report: {bin index, magnitude}.
    localparam int PEAK_LANE_W = 48;
    // Width of the zero-extended bin index field inside a peak report lane.
    localparam int PEAK_IDX_W  = PEAK_LANE_W - MAG_W;

    // One complex FFT bin as it appears on the input bus: {im, re}.
    typedef struct packed {
        logic [BIN_W-1:0] im;
        logic [BIN_W-1:0] re;
    } bin_t;

    // Ceiling log2, used to size bin counters.  clogb2(1) = 0.
    function automatic int clogb2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : fft_dsp_pkg
`default_nettype wire

// File: rtl/fft_mag_lane.sv
`default_nettype none
// ============================================================================
//  Module      : fft_mag_lane
//  Description : One lane of the FFT magnitude / peak datapath.
//                S1 registers re*re and im*im, S2 registers their sum as an
//                unsigned |X|^2.  The S2 output is compared against the
//                running frame peak on every output handshake, and the peak
//                is copied to the report register at end of frame.
//  Ports       : clk, rst      - clock, asynchronous active-high reset
//                i_s1_load     - input beat accepted into S1
//                i_s2_load     - S1 content moves into S2
//                i_bin         - {im, re} two's complement bin
//                i_hs          - S2 beat accepted downstream
//                i_first       - the accepted beat is bin 0 of a frame
//                i_eof         - the accepted beat ends the frame
//                i_idx         - bin index of the accepted beat
//                o_mag         - S2 magnitude
//                o_report      - {zero-extended peak index, peak magnitude}
//  Revision    : 1.0  initial release
// ============================================================================
module fft_mag_lane
    import fft_dsp_pkg::*;
#(
    parameter int IDX_W = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_s1_load,
    input  logic                   i_s2_load,
    input  logic [2*BIN_W-1:0]     i_bin,
    input  logic                   i_hs,
    input  logic                   i_first,
    input  logic                   i_eof,
    input  logic [IDX_W-1:0]       i_idx,
    output logic [MAG_W-1:0]       o_mag,
    output logic [PEAK_LANE_W-1:0] o_report
);

    bin_t                     w_bin;
    logic signed [BIN_W-1:0]  w_re;
    logic signed [BIN_W-1:0]  w_im;
    logic signed [MAG_W-1:0]  w_re_sq;
    logic signed [MAG_W-1:0]  w_im_sq;
    logic [MAG_W-1:0]         w_sum;

    logic signed [MAG_W-1:0]  r_re_sq;
    logic signed [MAG_W-1:0]  r_im_sq;
    logic [MAG_W-1:0]         r_mag;

    logic [MAG_W-1:0]         r_peak_mag;
    logic [IDX_W-1:0]         r_peak_idx;
    logic [MAG_W-1:0]         r_rpt_mag;
    logic [IDX_W-1:0]         r_rpt_idx;

    logic                     w_gt;
    logic [MAG_W-1:0]         w_peak_mag_nxt;
    logic [IDX_W-1:0]         w_peak_idx_nxt;

    assign w_bin = bin_t'(i_bin);
    assign w_re  = w_bin.re;
    assign w_im  = w_bin.im;

    // Signed 16x16 squares are never negative and at most 2^30, so the sum
    // of the two reaches at most 2^31 and fits the unsigned 32-bit result.
    assign w_re_sq = w_re * w_re;
    assign w_im_sq = w_im * w_im;
    assign w_sum   = $unsigned(r_re_sq) + $unsigned(r_im_sq);

    // Strict compare: on a tie the earlier (lower) bin is kept.  Bin 0
    // unconditionally restarts the search.
    assign w_gt           = r_mag > r_peak_mag;
    assign w_peak_mag_nxt = (i_first || w_gt) ? r_mag : r_peak_mag;
    assign w_peak_idx_nxt = i_first ? '0 : (w_gt ? i_idx : r_peak_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_re_sq    <= '0;
            r_im_sq    <= '0;
            r_mag      <= '0;
            r_peak_mag <= '0;
            r_peak_idx <= '0;
            r_rpt_mag  <= '0;
            r_rpt_idx  <= '0;
        end else begin
            if (i_s1_load) begin
                r_re_sq <= w_re_sq;
                r_im_sq <= w_im_sq;
            end
            if (i_s2_load) begin
                r_mag <= w_sum;
            end
            if (i_hs) begin
                r_peak_mag <= w_peak_mag_nxt;
                r_peak_idx <= w_peak_idx_nxt;
                // The report includes the comparison of the closing beat.
                if (i_eof) begin
                    r_rpt_mag <= w_peak_mag_nxt;
                    r_rpt_idx <= w_peak_idx_nxt;
                end
            end
        end
    end

    assign o_mag    = r_mag;
    assign o_report = {PEAK_IDX_W'(r_rpt_idx), r_rpt_mag};

endmodule : fft_mag_lane
`default_nettype wire

// File: rtl/fft_mag_peak.sv
`default_nettype none
// ============================================================================
//  Module      : fft_mag_peak
//  Description : FFT post-processor.  Converts each lane of the complex-bin
//                AXI-Stream into |X|^2 through a 2-stage elastic pipeline and
//                reports the peak bin of every lane once per frame.
//  Ports       : aclk, areset           - clock, asynchronous active-high reset
//                s_axis_*               - FFT bins in, lane c at [32c+31:32c]
//                m_axis_*               - |X|^2 out, lane c at [32c+31:32c]
//                m_peak_*               - per-frame peak report, 48 bits/lane
//                evt_peak_overrun       - pulse: pending report overwritten
//                evt_tlast_missing      - pulse: frame closed by bin count
//                evt_tlast_unexpected   - pulse: frame closed early by tlast
//                frame_count            - reports generated (wrapping)
//  Revision    : 1.0  initial release
// ============================================================================
module fft_mag_peak
    import fft_dsp_pkg::*;
#(
    parameter int FFT_LEN            = 8192,
    parameter int FFT_CHANNELS       = 2,
    parameter int FFT_AXI_DATA_WIDTH = 32
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic [FFT_CHANNELS*FFT_AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                                   s_axis_tvalid,
    input  logic                                   s_axis_tlast,
    output logic                                   s_axis_tready,
    output logic [FFT_CHANNELS*MAG_W-1:0]          m_axis_tdata,
    output logic                                   m_axis_tvalid,
    output logic                                   m_axis_tlast,
    input  logic                                   m_axis_tready,
    output logic [FFT_CHANNELS*PEAK_LANE_W-1:0]    m_peak_tdata,
    output logic                                   m_peak_tvalid,
    input  logic                                   m_peak_tready,
    output logic                                   evt_peak_overrun,
    output logic                                   evt_tlast_missing,
    output logic                                   evt_tlast_unexpected,
    output logic [15:0]                            frame_count
);

    localparam int               IDX_W    = clogb2(FFT_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FFT_LEN - 1);

    // Input is held off for the first cycle after reset so that s_axis_tready
    // reads 0 while reset is asserted, like every other output.
    logic             r_en;
    logic             r_v1;
    logic             r_last1;
    logic             r_v2;
    logic             r_last2;
    logic [IDX_W-1:0] r_idx;
    logic             r_pk_valid;
    logic [15:0]      r_frame_count;
    logic             r_evt_overrun;
    logic             r_evt_missing;
    logic             r_evt_unexp;

    logic             w_adv1;
    logic             w_adv2;
    logic             w_accept;
    logic             w_s2_load;
    logic             w_out_hs;
    logic             w_first;
    logic             w_idx_last;
    logic             w_eof;
    logic             w_load;

    // Elastic handshake: a stage may advance when it is empty or the stage
    // after it is advancing.
    assign w_adv2    = !r_v2 || m_axis_tready;
    assign w_adv1    = !r_v1 || w_adv2;
    assign w_accept  = s_axis_tvalid && s_axis_tready;
    assign w_s2_load = w_adv2 && r_v1;
    assign w_out_hs  = r_v2 && m_axis_tready;

    // Frame bookkeeping follows the output handshake, so the bin index
    // always refers to the magnitude currently leaving S2.
    assign w_first    = (r_idx == '0);
    assign w_idx_last = (r_idx == IDX_LAST);
    assign w_eof      = r_last2 || w_idx_last;
    assign w_load     = w_out_hs && w_eof;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_en    <= 1'b0;
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_v2    <= 1'b0;
            r_last2 <= 1'b0;
        end else begin
            r_en <= 1'b1;
            if (w_adv1) begin
                r_v1    <= w_accept;
                r_last1 <= s_axis_tlast;
            end
            if (w_adv2) begin
                r_v2    <= r_v1;
                r_last2 <= r_last1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_idx         <= '0;
            r_pk_valid    <= 1'b0;
            r_frame_count <= '0;
            r_evt_overrun <= 1'b0;
            r_evt_missing <= 1'b0;
            r_evt_unexp   <= 1'b0;
        end else begin
            if (w_out_hs) begin
                r_idx <= w_eof ? '0 : r_idx + 1'b1;
            end
            // A fresh load wins over a consuming tready in the same cycle.
            if (w_load) begin
                r_pk_valid <= 1'b1;
            end else if (m_peak_tready) begin
                r_pk_valid <= 1'b0;
            end
            if (w_load) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
            r_evt_overrun <= w_load && r_pk_valid && !m_peak_tready;
            r_evt_missing <= w_out_hs && w_idx_last && !r_last2;
            r_evt_unexp   <= w_out_hs && r_last2 && !w_idx_last;
        end
    end

    for (genvar c = 0; c < FFT_CHANNELS; c++) begin : g_lane
        fft_mag_lane #(
            .IDX_W (IDX_W)
        ) u_lane (
            .clk       (aclk),
            .rst       (areset),
            .i_s1_load (w_accept),
            .i_s2_load (w_s2_load),
            .i_bin     (s_axis_tdata[c*FFT_AXI_DATA_WIDTH +: 2*BIN_W]),
            .i_hs      (w_out_hs),
            .i_first   (w_first),
            .i_eof     (w_eof),
            .i_idx     (r_idx),
            .o_mag     (m_axis_tdata[c*MAG_W +: MAG_W]),
            .o_report  (m_peak_tdata[c*PEAK_LANE_W +: PEAK_LANE_W])
        );
    end

    assign s_axis_tready        = r_en && w_adv1;
    assign m_axis_tvalid        = r_v2;
    assign m_axis_tlast         = r_last2;
    assign m_peak_tvalid        = r_pk_valid;
    assign evt_peak_overrun     = r_evt_overrun;
    assign evt_tlast_missing    = r_evt_missing;
    assign evt_tlast_unexpected = r_evt_unexp;
    assign frame_count          = r_frame_count;

endmodule : fft_mag_peak
`default_nettype wire

// File: tb/tb_fft_mag_peak.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_mag_peak
//  Description : Directed self-checking bench for fft_mag_peak with
//                FFT_LEN = 8 and two lanes.  Inputs change 1 ns after the
//                rising edge; outputs are read 2 ns after the rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fft_mag_peak;

    localparam int LEN = 8;
    localparam int CH  = 2;

    logic          aclk = 1'b0;
    logic          areset;
    logic [63:0]   s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [63:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic [95:0]   m_peak_tdata;
    logic          m_peak_tvalid;
    logic          m_peak_tready;
    logic          evt_peak_overrun;
    logic          evt_tlast_missing;
    logic          evt_tlast_unexpected;
    logic [15:0]   frame_count;

    int total = 0;
    int bad   = 0;
    int n_ovr = 0;
    int n_miss = 0;
    int n_unexp = 0;

    fft_mag_peak #(
        .FFT_LEN            (LEN),
        .FFT_CHANNELS       (CH),
        .FFT_AXI_DATA_WIDTH (32)
    ) dut (
        .aclk                 (aclk),
        .areset               (areset),
        .s_axis_tdata         (s_axis_tdata),
        .s_axis_tvalid        (s_axis_tvalid),
        .s_axis_tlast         (s_axis_tlast),
        .s_axis_tready        (s_axis_tready),
        .m_axis_tdata         (m_axis_tdata),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tlast         (m_axis_tlast),
        .m_axis_tready        (m_axis_tready),
        .m_peak_tdata         (m_peak_tdata),
        .m_peak_tvalid        (m_peak_tvalid),
        .m_peak_tready        (m_peak_tready),
        .evt_peak_overrun     (evt_peak_overrun),
        .evt_tlast_missing    (evt_tlast_missing),
        .evt_tlast_unexpected (evt_tlast_unexpected),
        .frame_count          (frame_count)
    );

    always #5 aclk = ~aclk;

    // Event pulse counters, read as differences by the tests.
    always @(negedge aclk) begin
        if (evt_peak_overrun === 1'b1)     n_ovr++;
        if (evt_tlast_missing === 1'b1)    n_miss++;
        if (evt_tlast_unexpected === 1'b1) n_unexp++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] mk(input int re0, input int im0, input int re1, input int im1);
        return {im1[15:0], re1[15:0], im0[15:0], re0[15:0]};
    endfunction

    function automatic logic [31:0] magf(input logic [15:0] re, input logic [15:0] im);
        longint r;
        longint i;
        longint s;
        r = longint'($signed(re));
        i = longint'($signed(im));
        s = r * r + i * i;
        return s[31:0];
    endfunction

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Presents one beat and holds it until accepted (bounded).
    task automatic send(input logic [63:0] d, input logic last);
        bit ok;
        ok = 1'b0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            #1;
            ok = s_axis_tready;
            @(posedge aclk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout got=no_accept want=accept");
        end
    endtask

    task automatic do_reset();
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic test_reset();
        m_axis_tready = 1'b1;
        m_peak_tready = 1'b1;
        @(posedge aclk);
        #2;
        total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL rst_s_ready got=%b want=0", s_axis_tready); end
        total++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== 66'd0) begin bad++; $display("FAIL rst_m_axis got=%h want=0", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}); end
        total++; if ({m_peak_tvalid, m_peak_tdata} !== 97'd0) begin bad++; $display("FAIL rst_peak got=%h want=0", {m_peak_tvalid, m_peak_tdata}); end
        total++; if ({evt_peak_overrun, evt_tlast_missing, evt_tlast_unexpected, frame_count} !== 19'd0) begin bad++; $display("FAIL rst_evt got=%h want=0", {evt_peak_overrun, evt_tlast_missing, evt_tlast_unexpected, frame_count}); end
        areset = 1'b0;
        step();
        step();
        total++; if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", s_axis_tready); end
    endtask

    task automatic test_mag();
        do_reset();
        m_axis_tready = 1'b1;
        m_peak_tready = 1'b1;
        send(mk(3, -4, 0, 0), 1'b0);
        total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL mag_lat_early got=%b want=0", m_axis_tvalid); end
        step();
        total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL mag_lat_valid got=%b want=1", m_axis_tvalid); end
        total++; if (m_axis_tdata !== {32'd0, 32'd25}) begin bad++; $display("FAIL mag_3_4 got=%h want=%h", m_axis_tdata, {32'd0, 32'd25}); end
        send(mk(-32768, -32768, 1, -1), 1'b0);
        step();
        total++; if (m_axis_tdata !== {32'd2, 32'h80000000}) begin bad++; $display("FAIL mag_max got=%h want=%h", m_axis_tdata, {32'd2, 32'h80000000}); end
        total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("FAIL mag_tlast got=%b want=0", m_axis_tlast); end
    endtask

    task automatic test_peak();
        do_reset();
        m_axis_tready = 1'b1;
        m_peak_tready = 1'b0;
        for (int b = 0; b < LEN; b++)
            send(mk(b == 5 ? 100 : 0, b == 2 ? -100 : 0, 0, 0), b == LEN - 1);
        repeat (6) step();
        total++; if (m_peak_tvalid !== 1'b1) begin bad++; $display("FAIL peak_valid got=%b want=1", m_peak_tvalid); end
        total++; if (m_peak_tdata[47:0] !== {16'd2, 32'd10000}) begin bad++; $display("FAIL peak_lane0 got=%h want=%h", m_peak_tdata[47:0], {16'd2, 32'd10000}); end
        total++; if (m_peak_tdata[95:48] !== 48'd0) begin bad++; $display("FAIL peak_lane1 got=%h want=0", m_peak_tdata[95:48]); end
        total++; if (frame_count !== 16'd1) begin bad++; $display("FAIL peak_count got=%0d want=1", frame_count); end
        m_peak_tready = 1'b1;
        step();
        m_peak_tready = 1'b0;
        total++; if (m_peak_tvalid !== 1'b0) begin bad++; $display("FAIL peak_consume got=%b want=0", m_peak_tvalid); end
    endtask

    task automatic test_random();
        logic [64:0] exp_q[$];
        logic [95:0] pk_q[$];
        logic [64:0] e;
        logic [95:0] ep;
        logic [15:0] rr[CH];
        logic [15:0] ii[CH];
        logic [31:0] pm[CH];
        int          pi[CH];
        logic [31:0] m;
        logic [63:0] cur;
        logic [63:0] prev_d;
        logic        prev_l;
        bit          pend;
        bit          prev_stall;
        int          bc;
        int          sent;
        int          got;
        int          pk_got;
        int          o0;
        pend = 0; prev_stall = 0; bc = 0; sent = 0; got = 0; pk_got = 0;
        cur = '0; prev_d = '0; prev_l = 1'b0;
        do_reset();
        m_peak_tready = 1'b1;
        o0 = n_ovr;
        for (int cyc = 0; cyc < 20000 && (got < 50 * LEN || pk_got < 50); cyc++) begin
            if (!pend && sent < 50 * LEN && $urandom_range(0, 99) < 40) begin
                for (int c = 0; c < CH; c++) begin
                    rr[c] = 16'($urandom);
                    ii[c] = 16'($urandom);
                    if ($urandom_range(0, 9) == 0) begin rr[c] = 16'h8000; ii[c] = 16'h8000; end
                end
                cur  = {ii[1], rr[1], ii[0], rr[0]};
                pend = 1;
            end
            s_axis_tvalid = pend;
            s_axis_tdata  = cur;
            s_axis_tlast  = (bc == LEN - 1);
            m_axis_tready = ($urandom_range(0, 99) < 30);
            #1;
            if (prev_stall) begin
                total++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_d || m_axis_tlast !== prev_l) begin
                    bad++; $display("FAIL rnd_hold got=%b/%h want=1/%h", m_axis_tvalid, m_axis_tdata, prev_d);
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_d = m_axis_tdata;
            prev_l = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rnd_extra got=%h want=none", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_axis_tlast, m_axis_tdata} !== e) begin
                        bad++; $display("FAIL rnd_beat got=%h want=%h", {m_axis_tlast, m_axis_tdata}, e);
                    end
                end
                got++;
            end
            if (m_peak_tvalid) begin
                total++;
                if (pk_q.size() == 0) begin
                    bad++; $display("FAIL rnd_peak_extra got=%h want=none", m_peak_tdata);
                end else begin
                    ep = pk_q.pop_front();
                    if (m_peak_tdata !== ep) begin
                        bad++; $display("FAIL rnd_peak got=%h want=%h", m_peak_tdata, ep);
                    end
                end
                pk_got++;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                for (int c = 0; c < CH; c++) begin
                    m = magf(cur[c*32 +: 16], cur[c*32+16 +: 16]);
                    e[c*32 +: 32] = m;
                    if (bc == 0) begin pm[c] = m; pi[c] = 0; end
                    else if (m > pm[c]) begin pm[c] = m; pi[c] = bc; end
                end
                e[64] = (bc == LEN - 1);
                exp_q.push_back(e);
                if (bc == LEN - 1)
                    pk_q.push_back({16'(pi[1]), pm[1], 16'(pi[0]), pm[0]});
                bc   = (bc == LEN - 1) ? 0 : bc + 1;
                pend = 0;
                sent++;
            end
            @(posedge aclk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        total++; if (got != 50 * LEN || pk_got != 50) begin bad++; $display("FAIL rnd_count got=%0d/%0d want=%0d/50", got, pk_got, 50 * LEN); end
        total++; if (n_ovr != o0) begin bad++; $display("FAIL rnd_no_overrun got=%0d want=0", n_ovr - o0); end
    endtask

    task automatic test_overrun();
        int  o0;
        bit  hit;
        do_reset();
        m_axis_tready = 1'b1;
        m_peak_tready = 1'b0;
        o0 = n_ovr;
        for (int f = 0; f < 2; f++)
            for (int b = 0; b < LEN; b++)
                send(f == 0 ? mk(b == 3 ? 10 : 0, 0, b == 1 ? 2 : 0, 0)
                            : mk(b == 6 ? 20 : 0, 0, 0, b == 4 ? 3 : 0), b == LEN - 1);
        repeat (6) step();
        total++; if (n_ovr - o0 != 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=1", n_ovr - o0); end
        total++; if (m_peak_tdata !== {16'd4, 32'd9, 16'd6, 32'd400}) begin bad++; $display("FAIL ovr_report got=%h want=%h", m_peak_tdata, {16'd4, 32'd9, 16'd6, 32'd400}); end
        total++; if (frame_count !== 16'd2) begin bad++; $display("FAIL ovr_count got=%0d want=2", frame_count); end
        for (int b = 0; b < LEN; b++)
            send(mk(b == 0 ? 1 : 0, 0, b == 7 ? 7 : 0, 0), b == LEN - 1);
        hit = 0;
        for (int k = 0; k < 10 && !hit; k++) begin
            #1;
            if (m_axis_tvalid && m_axis_tlast) begin m_peak_tready = 1'b1; hit = 1; end
            @(posedge aclk);
            #1;
            m_peak_tready = 1'b0;
        end
        total++; if (!hit) begin bad++; $display("FAIL ovr_load_seen got=0 want=1"); end
        repeat (3) step();
        total++; if (n_ovr - o0 != 1) begin bad++; $display("FAIL ovr_same_cycle got=%0d want=1", n_ovr - o0); end
        total++; if (m_peak_tvalid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", m_peak_tvalid); end
        total++; if (m_peak_tdata !== {16'd7, 32'd49, 16'd0, 32'd1}) begin bad++; $display("FAIL ovr_report3 got=%h want=%h", m_peak_tdata, {16'd7, 32'd49, 16'd0, 32'd1}); end
        total++; if (frame_count !== 16'd3) begin bad++; $display("FAIL ovr_count3 got=%0d want=3", frame_count); end
    endtask

    task automatic test_tlast();
        int a0[5] = '{1, 2, 9, 3, 4};
        int u0;
        int m0;
        do_reset();
        m_axis_tready = 1'b1;
        m_peak_tready = 1'b0;
        u0 = n_unexp;
        m0 = n_miss;
        for (int b = 0; b < 5; b++)
            send(mk(a0[b], 0, b == 0 ? 5 : 0, 0), b == 4);
        repeat (6) step();
        total++; if (n_unexp - u0 != 1 || n_miss != m0) begin bad++; $display("FAIL tl_unexp got=%0d/%0d want=1/0", n_unexp - u0, n_miss - m0); end
        total++; if (m_peak_tdata !== {16'd0, 32'd25, 16'd2, 32'd81}) begin bad++; $display("FAIL tl_short_report got=%h want=%h", m_peak_tdata, {16'd0, 32'd25, 16'd2, 32'd81}); end
        m_peak_tready = 1'b1;
        step();
        m_peak_tready = 1'b0;
        for (int b = 0; b < 9; b++)
            send(mk(b == 1 ? 7 : (b == 8 ? 2 : 0), 0, b == 7 ? 6 : 0, 0), 1'b0);
        repeat (6) step();
        total++; if (n_miss - m0 != 1 || n_unexp - u0 != 1) begin bad++; $display("FAIL tl_missing got=%0d/%0d want=1/1", n_miss - m0, n_unexp - u0); end
        total++; if (m_peak_tdata !== {16'd7, 32'd36, 16'd1, 32'd49}) begin bad++; $display("FAIL tl_long_report got=%h want=%h", m_peak_tdata, {16'd7, 32'd36, 16'd1, 32'd49}); end
        m_peak_tready = 1'b1;
        step();
        m_peak_tready = 1'b0;
        for (int b = 1; b < LEN; b++)
            send(mk(1, 0, 0, 0), b == LEN - 1);
        repeat (6) step();
        total++; if (m_peak_tdata !== {16'd0, 32'd0, 16'd0, 32'd4}) begin bad++; $display("FAIL tl_restart got=%h want=%h", m_peak_tdata, {16'd0, 32'd0, 16'd0, 32'd4}); end
        total++; if (n_miss - m0 != 1 || n_unexp - u0 != 1 || frame_count !== 16'd3) begin bad++; $display("FAIL tl_clean got=%0d/%0d/%0d want=1/1/3", n_miss - m0, n_unexp - u0, frame_count); end
    endtask

    task automatic test_reset_mid();
        int u0;
        do_reset();
        m_axis_tready = 1'b1;
        m_peak_tready = 1'b1;
        for (int b = 0; b < 5; b++)
            send(mk(b == 1 ? 200 : 0, 0, 0, b == 1 ? 50 : 0), 1'b0);
        total++; if (m_axis_tvalid !== 1'b1) begin bad++; $display("FAIL mid_full got=%b want=1", m_axis_tvalid); end
        areset = 1'b1;
        #1;
        total++; if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== 67'd0) begin bad++; $display("FAIL mid_m_axis got=%h want=0", {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata}); end
        total++; if ({m_peak_tvalid, m_peak_tdata, frame_count} !== 113'd0) begin bad++; $display("FAIL mid_peak got=%h want=0", {m_peak_tvalid, m_peak_tdata, frame_count}); end
        step();
        step();
        areset        = 1'b0;
        m_peak_tready = 1'b0;
        u0 = n_unexp;
        for (int b = 0; b < LEN; b++)
            send(mk(b == 3 ? 30 : 1, 0, 5, 0), b == LEN - 1);
        repeat (6) step();
        total++; if (m_peak_tdata !== {16'd0, 32'd25, 16'd3, 32'd900}) begin bad++; $display("FAIL mid_report got=%h want=%h", m_peak_tdata, {16'd0, 32'd25, 16'd3, 32'd900}); end
        total++; if (frame_count !== 16'd1 || n_unexp != u0) begin bad++; $display("FAIL mid_count got=%0d/%0d want=1/0", frame_count, n_unexp - u0); end
    endtask

    initial begin
        areset        = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        m_peak_tready = 1'b0;
        #3;
        areset = 1'b1;
        test_reset();
        test_mag();
        test_peak();
        test_random();
        test_overrun();
        test_tlast();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fft_mag_peak
`default_nettype wire
